// File: rtl/uart_pkg.sv
// Shared UART constants and baud generator defaults.
// Pure declarations: no timing, no flow control.
package uart_pkg;
    localparam int UART_DATA_BITS      = 8;
    localparam int UART_STOP_BITS      = 1;
    localparam int BAUD_OSR_DEFAULT    = 16;
    localparam int BAUD_DIV_W_DEFAULT  = 16;
    localparam int BAUD_FRAC_W_DEFAULT = 4;
    localparam int BAUD_DIV_MIN        = 2;
endpackage

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator: carry is the overflow of acc + div_frac for the current interval.
// Carry is combinational from the registered acc; acc advances one cycle after step; no backpressure.
module baud_frac_acc
    import uart_pkg::*;
#(
    parameter int FRAC_W = BAUD_FRAC_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              clear,
    input  logic              step,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              carry
);

    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, div_frac};
    assign carry = sum[FRAC_W];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (step) begin
            acc_q <= sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick every div_int(+carry) clocks, with bit-centre/bit-end pulses.
// All outputs registered (one cycle after the deciding edge); free-running, no backpressure.
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int OSR    = BAUD_OSR_DEFAULT,
    parameter int DIV_W  = BAUD_DIV_W_DEFAULT,
    parameter int FRAC_W = BAUD_FRAC_W_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    en_i,
    input  logic                    sync_i,
    input  logic [DIV_W-1:0]        div_int_i,
    input  logic [FRAC_W-1:0]       div_frac_i,
    output logic                    osr_tick_o,
    output logic                    mid_tick_o,
    output logic                    baud_tick_o,
    output logic [$clog2(OSR)-1:0]  osr_cnt_o,
    output logic                    cfg_err_o
);

    localparam int OSR_W = $clog2(OSR);
    localparam logic [OSR_W-1:0] MID_IDX = OSR_W'(OSR / 2 - 1);
    localparam logic [OSR_W-1:0] END_IDX = OSR_W'(OSR - 1);

    logic [DIV_W-1:0]  div_int_q;
    logic [FRAC_W-1:0] div_frac_q;
    logic [DIV_W:0]    cyc_cnt_q;
    logic [DIV_W:0]    period;
    logic [OSR_W-1:0]  osr_cnt_q;
    logic              cfg_err_q;
    logic              osr_tick_q;
    logic              mid_tick_q;
    logic              baud_tick_q;
    logic              carry;
    logic              div_chg;
    logic              hold;
    logic              restart;
    logic              hit;
    logic              fire;

    // The counter is one bit wider than the divisor so a full 2^DIV_W period fits.
    always_comb begin
        hold    = !en_i || cfg_err_q;
        div_chg = {div_int_i, div_frac_i} != {div_int_q, div_frac_q};
        restart = div_chg || sync_i;
        period  = {1'b0, div_int_q} + {{DIV_W{1'b0}}, carry};
        hit     = (cyc_cnt_q + (DIV_W+1)'(1)) == period;
        fire    = !hold && !restart && hit;
    end

    baud_frac_acc #(
        .FRAC_W   (FRAC_W)
    ) u_frac_acc (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear    (hold || restart),
        .step     (fire),
        .div_frac (div_frac_q),
        .carry    (carry)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_int_q   <= '0;
            div_frac_q  <= '0;
            cfg_err_q   <= 1'b0;
            cyc_cnt_q   <= '0;
            osr_cnt_q   <= '0;
            osr_tick_q  <= 1'b0;
            mid_tick_q  <= 1'b0;
            baud_tick_q <= 1'b0;
        end else begin
            div_int_q   <= div_int_i;
            div_frac_q  <= div_frac_i;
            cfg_err_q   <= div_int_i < DIV_W'(BAUD_DIV_MIN);
            osr_tick_q  <= fire;
            mid_tick_q  <= fire && (osr_cnt_q == MID_IDX);
            baud_tick_q <= fire && (osr_cnt_q == END_IDX);

            if (hold || restart || hit) begin
                cyc_cnt_q <= '0;
            end else begin
                cyc_cnt_q <= cyc_cnt_q + (DIV_W+1)'(1);
            end

            // Index advances on the edge after the tick, so it reads pre-increment while the tick is high.
            if (hold || sync_i) begin
                osr_cnt_q <= '0;
            end else if (osr_tick_q) begin
                osr_cnt_q <= osr_cnt_q + OSR_W'(1);
            end
        end
    end

    assign osr_tick_o  = osr_tick_q;
    assign mid_tick_o  = mid_tick_q;
    assign baud_tick_o = baud_tick_q;
    assign osr_cnt_o   = osr_cnt_q;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: stimulus queues expected ticks, a negedge monitor checks them.
module tb_baud_gen_frac;

    typedef struct {
        int         edge_n;
        logic [3:0] cnt;
        logic       mid;
        logic       baud;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        en_i;
    logic        sync_i;
    logic [15:0] div_int_i;
    logic [3:0]  div_frac_i;
    logic        osr_tick_o;
    logic        mid_tick_o;
    logic        baud_tick_o;
    logic [3:0]  osr_cnt_o;
    logic        cfg_err_o;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t got_e;

    baud_gen_frac dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .en_i        (en_i),
        .sync_i      (sync_i),
        .div_int_i   (div_int_i),
        .div_frac_i  (div_frac_i),
        .osr_tick_o  (osr_tick_o),
        .mid_tick_o  (mid_tick_o),
        .baud_tick_o (baud_tick_o),
        .osr_cnt_o   (osr_cnt_o),
        .cfg_err_o   (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    // k is the running tick index since the last index clear.
    task automatic push(input int edge_n, input int k);
        exp_t e;
        e.edge_n = edge_n;
        e.cnt    = 4'(k % 16);
        e.mid    = (k % 16) == 7;
        e.baud   = (k % 16) == 15;
        exp_q.push_back(e);
    endtask

    task automatic to_edge(input int n);
        while (cyc < n) @(negedge clk_i);
    endtask

    // Monitor: every tick must match the head of the expectation queue.
    always @(negedge clk_i) begin
        if (osr_tick_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected osr_tick", osr_tick_o, 0);
            end else begin
                got_e = exp_q.pop_front();
                check("tick edge", cyc, got_e.edge_n);
                check("osr_cnt at tick", osr_cnt_o, got_e.cnt);
                check("mid_tick at tick", mid_tick_o, got_e.mid);
                check("baud_tick at tick", baud_tick_o, got_e.baud);
            end
        end else if (mid_tick_o || baud_tick_o) begin
            check("mid/baud without osr_tick", {mid_tick_o, baud_tick_o}, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int b2;
        reset_ni   = 1'b1;
        en_i       = 1'b0;
        sync_i     = 1'b0;
        div_int_i  = 16'd4;
        div_frac_i = 4'd0;
        #1 reset_ni = 1'b0;
        #1;
        check("reset osr_tick", osr_tick_o, 0);
        check("reset osr_cnt", osr_cnt_o, 0);
        check("reset cfg_err", cfg_err_o, 0);
        to_edge(3);
        check("reset mid/baud", {mid_tick_o, baud_tick_o}, 0);
        reset_ni = 1'b1;
        to_edge(cyc + 2);
        check("cfg_err with div_int=4", cfg_err_o, 0);

        // Integer divisor: tick every 4, baud every 16th tick, mid 8 ticks after baud.
        b = cyc;
        for (int k = 0; k < 32; k++) push(b + 4 * (k + 1), k);
        en_i = 1'b1;
        to_edge(b + 130);
        en_i = 1'b0;
        to_edge(b + 140);
        check("integer divisor ticks outstanding", exp_q.size(), 0);

        // Disable after 3 edges, then re-enable.
        b = cyc;
        en_i = 1'b1;
        to_edge(b + 3);
        en_i = 1'b0;
        to_edge(b + 12);
        check("osr_cnt after disable", osr_cnt_o, 0);
        b2 = cyc;
        push(b2 + 4, 0);
        en_i = 1'b1;
        to_edge(b2 + 5);
        check("osr_cnt after first tick", osr_cnt_o, 1);
        en_i = 1'b0;
        to_edge(b2 + 10);
        check("disable ticks outstanding", exp_q.size(), 0);

        // Fractional divisor 4 + 8/16: intervals 4,5,4,5,... 16 ticks in 72 cycles.
        div_frac_i = 4'd8;
        to_edge(cyc + 2);
        b = cyc;
        for (int k = 0; k < 16; k++) push(b + 4 * (k + 1) + (k + 1) / 2, k);
        en_i = 1'b1;
        to_edge(b + 73);
        en_i       = 1'b0;
        div_frac_i = 4'd0;
        to_edge(b + 78);
        check("fractional ticks outstanding", exp_q.size(), 0);

        // Divisor change 3 edges into an interval.
        to_edge(cyc + 2);
        b = cyc;
        push(b + 4, 0);
        push(b + 13, 1);
        push(b + 18, 2);
        en_i = 1'b1;
        to_edge(b + 7);
        div_int_i = 16'd5;
        to_edge(b + 8);
        check("osr_cnt kept on divisor change", osr_cnt_o, 1);
        to_edge(b + 19);
        en_i      = 1'b0;
        div_int_i = 16'd4;
        to_edge(b + 24);
        check("divisor change ticks outstanding", exp_q.size(), 0);

        // sync_i while osr_cnt is 9.
        to_edge(cyc + 2);
        b = cyc;
        for (int k = 0; k < 9; k++) push(b + 4 * (k + 1), k);
        push(b + 43, 0);
        push(b + 47, 1);
        en_i = 1'b1;
        to_edge(b + 38);
        check("osr_cnt before sync", osr_cnt_o, 9);
        sync_i = 1'b1;
        to_edge(b + 39);
        sync_i = 1'b0;
        check("osr_cnt after sync", osr_cnt_o, 0);
        to_edge(b + 48);
        en_i = 1'b0;
        to_edge(b + 53);
        check("sync ticks outstanding", exp_q.size(), 0);

        // Bad divisor: no ticks for 100 cycles, then recovery.
        b = cyc;
        div_int_i = 16'd1;
        en_i      = 1'b1;
        to_edge(b + 2);
        check("cfg_err with div_int=1", cfg_err_o, 1);
        to_edge(b + 100);
        check("cfg_err held", cfg_err_o, 1);
        div_int_i = 16'd4;
        to_edge(b + 101);
        check("cfg_err cleared", cfg_err_o, 0);
        push(b + 105, 0);
        to_edge(b + 106);
        en_i = 1'b0;
        to_edge(b + 110);
        check("cfg recovery ticks outstanding", exp_q.size(), 0);

        // Asynchronous reset mid-interval.
        to_edge(cyc + 2);
        b = cyc;
        push(b + 4, 0);
        push(b + 8, 1);
        en_i = 1'b1;
        to_edge(b + 10);
        check("osr_cnt before reset", osr_cnt_o, 2);
        #2 reset_ni = 1'b0;
        #1;
        check("async reset osr_cnt", osr_cnt_o, 0);
        check("async reset ticks", {osr_tick_o, mid_tick_o, baud_tick_o}, 0);
        check("async reset cfg_err", cfg_err_o, 0);
        en_i = 1'b0;
        to_edge(b + 12);
        reset_ni = 1'b1;
        to_edge(b + 14);
        push(b + 18, 0);
        en_i = 1'b1;
        to_edge(b + 19);
        en_i = 1'b0;
        to_edge(b + 24);
        check("post-reset ticks outstanding", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
